// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates I/D cache word requests onto a single-port
// word memory and returns reads through a fixed-latency, owner-tagged pipeline.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_read_req,
  input  logic              d_wrt,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic [DATA_W-1:0] mem_data,
  output logic              i_data_vld,
  output logic              d_data_vld
);
  localparam int WORDS = 1 << (ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t state, state_nxt;
  logic   i_req, d_req, rd_en, wr_en;
  logic [ADDR_W-2:0] widx;
  logic   unused_addr_lsb;

  logic [DATA_W-1:0] mem [WORDS];

  // vld_pipe/own_pipe/dat_pipe[k] hold the entry k+1 edges after its accept
  logic [LATENCY-1:0]             vld_pipe;
  logic [LATENCY-1:0]             own_pipe;  // 1 = D-cache
  logic [LATENCY-1:0][DATA_W-1:0] dat_pipe;

  assign i_req = i_read_req;
  assign d_req = d_read_req | d_wrt;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Owner keeps the memory until it drops its request; D wins ties from IDLE
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          state_nxt = OWN_D;
          d_gnt     = 1'b1;
        end else if (i_req) begin
          state_nxt = OWN_I;
          i_gnt     = 1'b1;
        end
      end
      OWN_I: begin
        if (i_req) i_gnt = 1'b1;
        else       state_nxt = IDLE;
      end
      OWN_D: begin
        if (d_req) d_gnt = 1'b1;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign widx  = d_gnt ? d_addr[ADDR_W-1:1] : i_addr[ADDR_W-1:1];
  assign wr_en = d_gnt & d_wrt & rst;
  assign rd_en = (i_gnt & i_read_req) | (d_gnt & d_read_req & ~d_wrt);
  assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= d_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], rd_en};
      own_pipe <= {own_pipe[LATENCY-2:0], d_gnt};
      dat_pipe <= {dat_pipe[LATENCY-2:0], mem[widx]};
    end
  end

  assign mem_data   = dat_pipe[LATENCY-1];
  assign i_data_vld = vld_pipe[LATENCY-1] & ~own_pipe[LATENCY-1];
  assign d_data_vld = vld_pipe[LATENCY-1] &  own_pipe[LATENCY-1];
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a negedge monitor pushes expected reads on
// grant and pops/compares them when a valid strobe appears.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_read_req = 1'b0, d_read_req = 1'b0, d_wrt = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, d_gnt, i_data_vld, d_data_vld;
  logic [15:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          own_d;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [int];

  mem_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_read_req(i_read_req), .i_addr(i_addr),
    .d_read_req(d_read_req), .d_wrt(d_wrt), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .mem_data(mem_data),
    .i_data_vld(i_data_vld), .d_data_vld(d_data_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    n_checks++;
    if (i_gnt && d_gnt) begin
      n_fail++;
      $display("FAIL grant_excl cyc=%0d: i_gnt=1 d_gnt=1, required at most one", cyc);
    end
    if (i_data_vld || d_data_vld) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld cyc=%0d: i_vld=%0b d_vld=%0b data=%h, none expected",
                 cyc, i_data_vld, d_data_vld, mem_data);
      end else begin
        e = sb.pop_front();
        if (i_data_vld === d_data_vld || d_data_vld !== e.own_d ||
            mem_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL sb_resp cyc=%0d: i_vld=%0b d_vld=%0b data=%h, required own_d=%0b data=%h cyc=%0d",
                   cyc, i_data_vld, d_data_vld, mem_data, e.own_d, e.data, e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      e = sb.pop_front();
      $display("FAIL missing_vld cyc=%0d: no valid, required own_d=%0b data=%h", cyc, e.own_d, e.data);
    end
    if (!rst) sb.delete();
    else begin
      if (d_gnt && d_wrt) model[int'(d_addr[15:1])] = d_wdata;
      else if (d_gnt && d_read_req)
        sb.push_back('{1'b1, model.exists(int'(d_addr[15:1])) ? model[int'(d_addr[15:1])] : 16'hxxxx, cyc + LAT});
      if (i_gnt && i_read_req)
        sb.push_back('{1'b0, model.exists(int'(i_addr[15:1])) ? model[int'(i_addr[15:1])] : 16'hxxxx, cyc + LAT});
    end
  end

  task automatic d_op(input bit wr, input logic [15:0] a, input logic [15:0] wd);
    d_wrt = wr; d_read_req = !wr; d_addr = a; d_wdata = wd;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (d_gnt) break;
    end
    n_checks++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL d_gnt_wait addr=%h: d_gnt=%b, required 1 within 16 cycles", a, d_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic i_op(input logic [15:0] a, output int waited);
    i_read_req = 1'b1; i_addr = a; waited = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (i_gnt) break;
      waited++;
    end
    n_checks++;
    if (i_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL i_gnt_wait addr=%h: i_gnt=%b, required 1 within 16 cycles", a, i_gnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic d_idle();
    d_wrt = 1'b0; d_read_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({i_data_vld, d_data_vld, i_gnt, d_gnt} !== 4'b0 || mem_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: vld=%b%b gnt=%b%b data=%h, required all 0",
               i_data_vld, d_data_vld, i_gnt, d_gnt, mem_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic preload();
    d_op(1'b1, 16'h0246, 16'hBEEF);
    for (int k = 0; k < 8; k++) d_op(1'b1, 16'h1000 + 16'(2 * k), 16'h0800 + 16'(k));
    d_idle();
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_single_i();
    int w;
    i_op(16'h0246, w);
    i_read_req = 1'b0;
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL single_i_gnt: waited %0d cycles, required 0", w);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (i_data_vld !== (c == 4) || d_data_vld !== 1'b0 ||
          (c == 4 && mem_data !== 16'hBEEF)) begin
        n_fail++;
        $display("FAIL single_i C%0d: i_vld=%b d_vld=%b data=%h, required i_vld=%0b data=BEEF",
                 c, i_data_vld, d_data_vld, mem_data, c == 4);
      end
    end
    drain();
  endtask

  task automatic test_refill();
    for (int k = 0; k < 8; k++) d_op(1'b0, 16'h1000 + 16'(2 * k), 16'h0);
    d_idle();
    drain();
  endtask

  task automatic test_contention();
    i_read_req = 1'b1; i_addr = 16'h0246;
    d_read_req = 1'b1; d_addr = 16'h1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL contend_burst k=%0d: d_gnt=%b i_gnt=%b, required 1 0", k, d_gnt, i_gnt);
      end
      @(posedge clk); #1;
      d_addr = d_addr + 16'd2;
    end
    d_idle();
    @(negedge clk);
    n_checks++;
    if (d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_bubble: d_gnt=%b i_gnt=%b, required 0 0", d_gnt, i_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (i_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL contend_i_gnt: i_gnt=%b, required 1", i_gnt);
    end
    @(posedge clk); #1;
    i_read_req = 1'b0;
    drain();
  endtask

  task automatic test_write_read();
    d_op(1'b1, 16'h2000, 16'hA5A5);
    d_op(1'b0, 16'h2000, 16'h0);
    d_idle();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (d_data_vld !== (c == 4) || i_data_vld !== 1'b0 ||
          (c == 4 && mem_data !== 16'hA5A5)) begin
        n_fail++;
        $display("FAIL raw C%0d: d_vld=%b i_vld=%b data=%h, required d_vld=%0b data=A5A5",
                 c, d_data_vld, i_data_vld, mem_data, c == 4);
      end
    end
    drain();
  endtask

  task automatic test_switch();
    int w;
    for (int k = 0; k < 3; k++) d_op(1'b0, 16'h1000 + 16'(2 * k), 16'h0);
    d_idle();
    i_op(16'h100A, w);
    n_checks++;
    if (w != 1) begin
      n_fail++;
      $display("FAIL switch_bubble: i waited %0d cycles, required 1", w);
    end
    i_op(16'h100C, w);
    i_read_req = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    for (int k = 0; k < 4; k++) d_op(1'b0, 16'h1000 + 16'(2 * k), 16'h0);
    d_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (i_data_vld !== 1'b0 || d_data_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d: i_vld=%b d_vld=%b, required 0 0", c, i_data_vld, d_data_vld);
      end
    end
    @(posedge clk); #1;
    i_op(16'h0246, w);
    i_read_req = 1'b0;
    n_checks++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: i waited %0d cycles, required 0", w);
    end
    drain();
  endtask

  initial begin
    test_reset();
    preload();
    test_single_i();
    test_refill();
    test_contention();
    test_write_read();
    test_switch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1);
  end
endmodule
